led_pattern_ctrl: RTL and testbench
===================================

Name: led_pattern_ctrl

Overview:
- Parametrised multi-channel LED driver; successor to the free-running counter blinker on the board top level.
- Each channel has its own mode: OFF, ON, BLINK at a selectable rate, or PWM dimming at a programmable duty. Channels are set through a valid/ready config port.
- Sits between board LED pins and a control source (UART/regfile/test FSM). Per-channel output polarity is handled internally, so active-low pins (e.g. LEDG_N/LEDR_N) need no external inversion.

Parameters:
- NUM_CH, 7: number of LED channels (1..32).
- TICK_DIV, 12000: CLK cycles per blink tick (12 MHz → 1 kHz tick). Must be ≥2.
- PWM_W, 8: PWM counter and duty width.
- ACTIVE_LOW_MASK, 7'b0000011: bit i = 1 means channel i pin is active-low. Width NUM_CH.

Ports:
- CLK, in, 1: system clock.
- RST_N, in, 1: asynchronous active-low reset.
- cfg_valid, in, 1: config request.
- cfg_ready, out, 1: block can accept config.
- cfg_ch, in, CW = max(1, clog2(NUM_CH)): target channel.
- cfg_mode, in, 2: 0 OFF, 1 ON, 2 BLINK, 3 PWM.
- cfg_rate, in, 4: BLINK rate select.
- cfg_duty, in, PWM_W: PWM duty.
- cfg_err, out, 1: one-cycle pulse when an accepted cfg_ch ≥ NUM_CH.
- tick, out, 1: one-cycle pulse per blink tick.
- led_out, out, NUM_CH: pin-level LED drive.

Behaviour:
- Reset (async assert, sync release) sets:
  - all state to zero;
  - every channel to mode OFF, rate 0, duty 0;
  - cfg_ready=1, cfg_err=0, tick=0;
  - led_out=ACTIVE_LOW_MASK (all LEDs dark).
- Prescaler: 0..TICK_DIV-1 counter. It wraps to 0 when at TICK_DIV-1, and tick is registered high for that wrap cycle only.
- tick_cnt: 16-bit counter, +1 on each tick, wraps 0xFFFF→0.
- pwm_cnt: PWM_W-bit counter, +1 every CLK, wraps to 0. PWM period = 2^PWM_W cycles.
- Config handshake:
  - Accept when cfg_valid && cfg_ready, at rising edge k.
  - Channel registers for cfg_ch load mode/rate/duty at edge k.
  - cfg_ready=0 for the cycle after an accept, then returns to 1. Maximum throughput is one config per 2 cycles.
  - cfg_valid while cfg_ready=0 is ignored; the source must hold it.
  - cfg_ch ≥ NUM_CH: request is accepted, no channel state changes, cfg_err=1 during cycle k+1.
- Logical channel state, on_i:
  - OFF: 0.
  - ON: 1.
  - BLINK: tick_cnt[rate_i]. Toggles every 2^rate_i ticks; full period 2^(rate_i+1) ticks.
  - PWM: (pwm_cnt < duty_i). duty=0 gives always 0; duty=2^PWM_W-1 gives high for 2^PWM_W-1 of 2^PWM_W cycles.
- Output: led_out[i] registered as on_i XOR ACTIVE_LOW_MASK[i]. One cycle after state.
- Latency: config accepted at edge k appears on led_out at edge k+1.
- Phase: all channels share tick_cnt and pwm_cnt. Channels with the same BLINK rate toggle on the same edge. Config writes do not reset any counter.
- Mode change mid-pattern takes effect at the current counter phase, with no restart.
- Reset mid-operation: outputs go to reset values immediately (async), independent of CLK. Pending config is discarded.
- No glitches: led_out is driven only from flops.

Test Plan:
- Reset and idle: RST_N low, 20 CLK, then release.
  - Required: led_out=7'b0000011, cfg_ready=1, cfg_err=0.
  - With TICK_DIV=4, first tick pulse at cycle 4 after release, then every 4 cycles.
- ON latency: write ch2 mode=1 (accept at edge k).
  - Required: led_out[2]=1 from edge k+1; cfg_ready=0 in cycle k+1 and 1 at k+2.
  - Then write ch0 mode=1: led_out[0]=0 (active-low on).
- BLINK: TICK_DIV=4; ch3 mode=2 rate=1.
  - Required: led_out[3] toggles every 8 CLK (2 ticks).
  - ch4 set to rate=1 later toggles on the same edges as ch3.
- PWM: PWM_W=8; ch5 mode=3 duty=64.
  - Required: exactly 64 high cycles per 256-cycle window.
  - duty=0: always low. duty=255: 255 of 256 high.
- Error and hold: NUM_CH=7; write cfg_ch=7 mode=1.
  - Required: cfg_err pulses for exactly 1 cycle; led_out unchanged.
  - Held cfg_valid on back-to-back writes: accepted every 2nd cycle, none lost.
- Reset mid-operation: ch1 BLINK, ch5 PWM running; assert RST_N between CLK edges.
  - Required: led_out=ACTIVE_LOW_MASK without waiting for a CLK edge.
  - After release, all channels are OFF until reconfigured.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: multi-channel LED driver with per-channel OFF / ON /
// BLINK / PWM modes, set through a valid/ready config port.
// All channels share one blink tick counter and one PWM counter, so channels
// in the same mode and rate stay phase-locked. Pin polarity is applied at the
// output flop, so active-low pins need no external inversion.
// RST_N asserts asynchronously; its release is expected to be synchronous to
// CLK (driven from the board reset synchroniser).
module led_pattern_ctrl #(
    parameter int                NUM_CH          = 7,
    parameter int                TICK_DIV        = 12000,
    parameter int                PWM_W           = 8,
    parameter logic [NUM_CH-1:0] ACTIVE_LOW_MASK = 7'b0000011,
    localparam int               CW              = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CW-1:0]     cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [3:0]        cfg_rate,
    input  logic [PWM_W-1:0]  cfg_duty,
    output logic              cfg_err,
    output logic              tick,
    output logic [NUM_CH-1:0] led_out
);

    localparam int PRESC_W = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_t;

    logic [PRESC_W-1:0] r_presc;
    logic               r_tick;
    logic [15:0]        r_tick_cnt;
    logic [PWM_W-1:0]   r_pwm_cnt;
    logic               r_ready;
    logic               r_err;
    mode_t              r_mode [NUM_CH];
    logic [3:0]         r_rate [NUM_CH];
    logic [PWM_W-1:0]   r_duty [NUM_CH];
    logic [NUM_CH-1:0]  r_led;

    logic               w_presc_wrap;
    logic               w_accept;
    logic               w_ch_ok;
    logic [NUM_CH-1:0]  w_on;

    assign w_presc_wrap = (r_presc == PRESC_W'(TICK_DIV - 1));
    assign w_accept     = cfg_valid & r_ready;
    assign w_ch_ok      = (int'(cfg_ch) < NUM_CH);

    // Prescaler: wraps every TICK_DIV cycles, flags the wrap on tick and
    // advances the shared blink counter.
    // NOTE: state flops use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_presc    <= '0;
            r_tick     <= 1'b0;
            r_tick_cnt <= '0;
        end else if (w_presc_wrap) begin
            r_presc    <= '0;
            r_tick     <= 1'b1;
            r_tick_cnt <= r_tick_cnt + 16'd1;
        end else begin
            r_presc    <= r_presc + PRESC_W'(1);
            r_tick     <= 1'b0;
        end
    end

    // Free-running PWM counter; its full range is one PWM period.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
        end
    end

    // Handshake: ready drops for one cycle after each accept; an out-of-range
    // channel is still accepted but flagged on cfg_err for one cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ready <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            r_ready <= ~w_accept;
            r_err   <= w_accept & ~w_ch_ok;
        end
    end

    // Per-channel configuration registers, loaded on an accepted in-range write.
    // NOTE: these small arrays are real flops and must come up OFF, so they are reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_mode[i] <= MODE_OFF;
                r_rate[i] <= '0;
                r_duty[i] <= '0;
            end
        end else if (w_accept && w_ch_ok) begin
            r_mode[cfg_ch] <= mode_t'(cfg_mode);
            r_rate[cfg_ch] <= cfg_rate;
            r_duty[cfg_ch] <= cfg_duty;
        end
    end

    // Logical on/off per channel from its mode and the shared counters.
    // NOTE: default assignment first so no path leaves w_on unassigned (no latch).
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_on[i] = 1'b0;
            case (r_mode[i])
                MODE_ON:    w_on[i] = 1'b1;
                MODE_BLINK: w_on[i] = r_tick_cnt[r_rate[i]];
                MODE_PWM:   w_on[i] = (r_pwm_cnt < r_duty[i]);
                default:    w_on[i] = 1'b0;
            endcase
        end
    end

    // Pin drive: polarity applied here so the pins come straight from flops.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_led <= ACTIVE_LOW_MASK;
        end else begin
            r_led <= w_on ^ ACTIVE_LOW_MASK;
        end
    end

    assign cfg_ready = r_ready;
    assign cfg_err   = r_err;
    assign tick      = r_tick;
    assign led_out   = r_led;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed testbench for led_pattern_ctrl with a short tick divider.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_led_pattern_ctrl;

    localparam int         NUM_CH   = 7;
    localparam int         TICK_DIV = 4;
    localparam int         PWM_W    = 8;
    localparam logic [6:0] MASK     = 7'b0000011;

    logic        CLK;
    logic        RST_N;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_ch;
    logic [1:0]  cfg_mode;
    logic [3:0]  cfg_rate;
    logic [7:0]  cfg_duty;
    logic        cfg_err;
    logic        tick;
    logic [6:0]  led_out;

    int total = 0;
    int bad   = 0;

    led_pattern_ctrl #(
        .NUM_CH          (NUM_CH),
        .TICK_DIV        (TICK_DIV),
        .PWM_W           (PWM_W),
        .ACTIVE_LOW_MASK (MASK)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_mode  (cfg_mode),
        .cfg_rate  (cfg_rate),
        .cfg_duty  (cfg_duty),
        .cfg_err   (cfg_err),
        .tick      (tick),
        .led_out   (led_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One config write; returns on the falling edge just after the accepting
    // rising edge k, with cfg_valid already dropped.
    task automatic write_cfg(input logic [2:0] ch, input logic [1:0] mode,
                             input logic [3:0] rate, input logic [7:0] duty);
        int budget;
        @(negedge CLK);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_mode  = mode;
        cfg_rate  = rate;
        cfg_duty  = duty;
        budget    = 0;
        while (cfg_ready !== 1'b1 && budget < 10) begin
            @(negedge CLK);
            budget++;
        end
        total++;
        if (budget >= 10) begin
            bad++;
            $display("FAIL cfg_wait: cfg_ready=%b, required 1", cfg_ready);
        end
        @(posedge CLK);
        @(negedge CLK);
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        RST_N     = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_mode  = '0;
        cfg_rate  = '0;
        cfg_duty  = '0;
        repeat (20) @(posedge CLK);
        @(negedge CLK);
        total++;
        if (led_out !== MASK) begin bad++; $display("FAIL reset_led: got %b, required %b", led_out, MASK); end
        total++;
        if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b, required 1", cfg_ready); end
        total++;
        if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b, required 0", cfg_err); end
        total++;
        if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b, required 0", tick); end
        RST_N = 1'b1;
        // tick is high in the cycle after rising edges 4, 8, 12 following release
        for (int n = 1; n <= 12; n++) begin
            logic exp_tick;
            @(negedge CLK);
            exp_tick = (n % 4 == 0);
            total++;
            if (tick !== exp_tick) begin
                bad++;
                $display("FAIL tick_cycle%0d: got %b, required %b", n, tick, exp_tick);
            end
        end
    endtask

    task automatic test_on_latency();
        write_cfg(3'd2, 2'd1, 4'd0, 8'd0);
        total++;
        if (cfg_ready !== 1'b0) begin bad++; $display("FAIL on_ready_k1: got %b, required 0", cfg_ready); end
        total++;
        if (led_out[2] !== 1'b0) begin bad++; $display("FAIL on_led_k: got %b, required 0", led_out[2]); end
        @(negedge CLK);
        total++;
        if (cfg_ready !== 1'b1) begin bad++; $display("FAIL on_ready_k2: got %b, required 1", cfg_ready); end
        total++;
        if (led_out[2] !== 1'b1) begin bad++; $display("FAIL on_led_k1: got %b, required 1", led_out[2]); end
        write_cfg(3'd0, 2'd1, 4'd0, 8'd0);
        @(negedge CLK);
        total++;
        if (led_out !== 7'b0000110) begin bad++; $display("FAIL on_ch0_low: got %b, required %b", led_out, 7'b0000110); end
    endtask

    task automatic test_blink();
        logic prev;
        int   last;
        int   nchg;
        write_cfg(3'd3, 2'd2, 4'd1, 8'd0);
        @(negedge CLK);
        prev = led_out[3];
        last = -1;
        nchg = 0;
        for (int n = 0; n < 48; n++) begin
            @(negedge CLK);
            if (led_out[3] !== prev) begin
                if (last >= 0) begin
                    total++;
                    if (n - last != 8) begin
                        bad++;
                        $display("FAIL blink_period: got %0d cycles, required 8", n - last);
                    end
                end
                last = n;
                nchg++;
                prev = led_out[3];
            end
        end
        total++;
        if (nchg < 5) begin bad++; $display("FAIL blink_toggles: got %0d, required >=5", nchg); end
        // second channel at the same rate must track ch3 exactly
        write_cfg(3'd4, 2'd2, 4'd1, 8'd0);
        @(negedge CLK);
        for (int n = 0; n < 24; n++) begin
            @(negedge CLK);
            total++;
            if (led_out[4] !== led_out[3]) begin
                bad++;
                $display("FAIL blink_phase%0d: ch4=%b, required ch3=%b", n, led_out[4], led_out[3]);
            end
        end
    endtask

    task automatic test_pwm();
        logic [7:0] duties [4];
        int         exp_hi [4];
        duties = '{8'd64, 8'd0, 8'd255, 8'd1};
        exp_hi = '{64, 0, 255, 1};
        for (int d = 0; d < 4; d++) begin
            int ones;
            write_cfg(3'd5, 2'd3, 4'd0, duties[d]);
            @(negedge CLK);
            ones = 0;
            for (int n = 0; n < 256; n++) begin
                @(negedge CLK);
                if (led_out[5] === 1'b1) ones++;
            end
            total++;
            if (ones != exp_hi[d]) begin
                bad++;
                $display("FAIL pwm_duty%0d: got %0d high cycles, required %0d", duties[d], ones, exp_hi[d]);
            end
        end
    endtask

    task automatic test_error();
        write_cfg(3'd3, 2'd0, 4'd0, 8'd0);
        write_cfg(3'd4, 2'd0, 4'd0, 8'd0);
        write_cfg(3'd5, 2'd0, 4'd0, 8'd0);
        @(negedge CLK);
        total++;
        if (led_out !== 7'b0000110) begin bad++; $display("FAIL err_pre_led: got %b, required %b", led_out, 7'b0000110); end
        write_cfg(3'd7, 2'd1, 4'd0, 8'd0);
        total++;
        if (cfg_err !== 1'b1) begin bad++; $display("FAIL err_pulse: got %b, required 1", cfg_err); end
        for (int n = 0; n < 3; n++) begin
            @(negedge CLK);
            total++;
            if (cfg_err !== 1'b0) begin bad++; $display("FAIL err_len%0d: got %b, required 0", n, cfg_err); end
            total++;
            if (led_out !== 7'b0000110) begin bad++; $display("FAIL err_led%0d: got %b, required %b", n, led_out, 7'b0000110); end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge CLK);
        cfg_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cfg_ch   = 3'(3 + i);
            cfg_mode = 2'd1;
            total++;
            if (cfg_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d: got %b, required 1", i, cfg_ready); end
            @(negedge CLK);
            total++;
            if (cfg_ready !== 1'b0) begin bad++; $display("FAIL b2b_busy%0d: got %b, required 0", i, cfg_ready); end
            // presented while not ready: must be ignored
            cfg_ch   = 3'd1;
            cfg_mode = 2'd1;
            @(negedge CLK);
        end
        cfg_valid = 1'b0;
        @(negedge CLK);
        total++;
        if (led_out !== 7'b1111110) begin bad++; $display("FAIL b2b_led: got %b, required %b", led_out, 7'b1111110); end
    endtask

    task automatic test_reset_mid();
        write_cfg(3'd1, 2'd2, 4'd0, 8'd0);
        write_cfg(3'd5, 2'd3, 4'd0, 8'd128);
        repeat (10) @(negedge CLK);
        @(posedge CLK);
        #2;
        cfg_valid = 1'b1;
        cfg_ch    = 3'd2;
        cfg_mode  = 2'd1;
        RST_N     = 1'b0;
        #1;
        total++;
        if (led_out !== MASK) begin bad++; $display("FAIL async_led: got %b, required %b", led_out, MASK); end
        total++;
        if (cfg_ready !== 1'b1) begin bad++; $display("FAIL async_ready: got %b, required 1", cfg_ready); end
        total++;
        if (tick !== 1'b0) begin bad++; $display("FAIL async_tick: got %b, required 0", tick); end
        repeat (3) @(negedge CLK);
        cfg_valid = 1'b0;
        RST_N     = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge CLK);
            total++;
            if (led_out !== MASK) begin bad++; $display("FAIL post_reset_led%0d: got %b, required %b", n, led_out, MASK); end
        end
    endtask

    initial begin
        test_reset();
        test_on_latency();
        test_blink();
        test_pwm();
        test_error();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
